// File: rtl/bayer_mosaic.sv
// Re-mosaicking serializer: takes one {R,G1,G2,B} quad per 2x2 Bayer block and
// replays the samples as a pixel-raster Bayer stream for the frame's CFA phase.
module bayer_mosaic #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        row_phase,
  input  logic        col_phase,
  input  logic        quad_valid,
  input  logic [31:0] quad_data,
  output logic        quad_ready,
  output logic        pix_valid,
  output logic [7:0]  pix_data,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof
);

  localparam int NBLK   = WIDTH / 2;
  localparam int NBROW  = HEIGHT / 2;
  localparam int BLK_W  = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int BROW_W = (NBROW > 1) ? $clog2(NBROW) : 1;
  localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(NBLK - 1);
  localparam logic [BROW_W-1:0] LAST_BROW = BROW_W'(NBROW - 1);

  typedef enum logic {TOP = 1'b0, BOT = 1'b1} state_t;

  // Reorder a quad into {TL,TR,BL,BR} sensor positions for CFA phase {row,col}.
  function automatic logic [31:0] map_quad(input logic [31:0] q, input logic [1:0] ph);
    logic [7:0] r, g1, g2, b;
    r  = q[31:24];
    g1 = q[23:16];
    g2 = q[15:8];
    b  = q[7:0];
    case (ph)
      2'b00:   map_quad = {r, g1, g2, b};
      2'b01:   map_quad = {g1, r, b, g2};
      2'b10:   map_quad = {g1, b, r, g2};
      2'b11:   map_quad = {b, g1, g2, r};
      default: map_quad = {r, g1, g2, b};
    endcase
  endfunction

  state_t             state, state_nx;
  logic [BLK_W-1:0]   blk, blk_nx;
  logic [BROW_W-1:0]  brow, brow_nx;
  logic               half, half_nx;
  logic [1:0]         phase, phase_nx;
  logic [7:0]         tr_hold, tr_hold_nx;
  logic               valid_nx, sof_nx, eol_nx, eof_nx;
  logic [7:0]         data_nx;
  logic [15:0]        linebuf [NBLK];
  logic               lb_we;
  logic [15:0]        lb_wdata;
  logic [15:0]        lb_entry;
  logic               slot_free, first_quad;
  logic [1:0]         ph_eff;
  logic [31:0]        mapped;

  assign slot_free  = !pix_valid || pix_ready;
  assign first_quad = (blk == LAST_BLK - LAST_BLK) && (brow == LAST_BROW - LAST_BROW);
  assign ph_eff     = first_quad ? {row_phase, col_phase} : phase;
  assign mapped     = map_quad(quad_data, ph_eff);
  assign lb_entry   = linebuf[blk];
  assign quad_ready = !rst && (state == TOP) && !half && slot_free;

  // Next-state and next-output computation for the TOP/BOT serializer.
  always_comb begin
    state_nx   = state;
    blk_nx     = blk;
    brow_nx    = brow;
    half_nx    = half;
    phase_nx   = phase;
    tr_hold_nx = tr_hold;
    valid_nx   = pix_valid;
    data_nx    = pix_data;
    sof_nx     = pix_sof;
    eol_nx     = pix_eol;
    eof_nx     = pix_eof;
    lb_we      = 1'b0;
    lb_wdata   = 16'h0000;
    case (state)
      TOP: begin
        if (!half) begin
          if (quad_valid && quad_ready) begin
            data_nx    = mapped[31:24];
            tr_hold_nx = mapped[23:16];
            lb_we      = 1'b1;
            lb_wdata   = mapped[15:0];
            valid_nx   = 1'b1;
            sof_nx     = first_quad;
            eol_nx     = 1'b0;
            eof_nx     = 1'b0;
            half_nx    = 1'b1;
            phase_nx   = ph_eff;
          end else if (slot_free) begin
            valid_nx = 1'b0;
            sof_nx   = 1'b0;
            eol_nx   = 1'b0;
            eof_nx   = 1'b0;
          end else begin
            valid_nx = pix_valid;
          end
        end else begin
          if (slot_free) begin
            data_nx  = tr_hold;
            valid_nx = 1'b1;
            sof_nx   = 1'b0;
            eol_nx   = (blk == LAST_BLK);
            eof_nx   = 1'b0;
            half_nx  = 1'b0;
            if (blk == LAST_BLK) begin
              blk_nx   = LAST_BLK - LAST_BLK;
              state_nx = BOT;
            end else begin
              blk_nx = blk + BLK_W'(1);
            end
          end else begin
            valid_nx = pix_valid;
          end
        end
      end
      BOT: begin
        if (slot_free) begin
          data_nx  = half ? lb_entry[7:0] : lb_entry[15:8];
          valid_nx = 1'b1;
          sof_nx   = 1'b0;
          eol_nx   = half && (blk == LAST_BLK);
          eof_nx   = half && (blk == LAST_BLK) && (brow == LAST_BROW);
          half_nx  = !half;
          // Row finishes on BR of the last block; brow wrap starts a new frame.
          if (half && (blk == LAST_BLK)) begin
            blk_nx   = LAST_BLK - LAST_BLK;
            state_nx = TOP;
            brow_nx  = (brow == LAST_BROW) ? (LAST_BROW - LAST_BROW) : (brow + BROW_W'(1));
          end else if (half) begin
            blk_nx = blk + BLK_W'(1);
          end else begin
            blk_nx = blk;
          end
        end else begin
          valid_nx = pix_valid;
        end
      end
      default: state_nx = TOP;
    endcase
  end

  // Control state and registered pixel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TOP;
      blk       <= '0;
      brow      <= '0;
      half      <= 1'b0;
      phase     <= 2'b00;
      tr_hold   <= 8'h00;
      pix_valid <= 1'b0;
      pix_data  <= 8'h00;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
    end else begin
      state     <= state_nx;
      blk       <= blk_nx;
      brow      <= brow_nx;
      half      <= half_nx;
      phase     <= phase_nx;
      tr_hold   <= tr_hold_nx;
      pix_valid <= valid_nx;
      pix_data  <= data_nx;
      pix_sof   <= sof_nx;
      pix_eol   <= eol_nx;
      pix_eof   <= eof_nx;
    end
  end

  // Bottom-row {BL,BR} storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf[blk] <= lb_wdata;
    end
  end

endmodule

// File: tb/tb_bayer_mosaic.sv
// Directed bench for bayer_mosaic at WIDTH=4, HEIGHT=2 (two quads per frame).
module tb_bayer_mosaic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        row_phase = 1'b0;
  logic        col_phase = 1'b0;
  logic        quad_valid = 1'b0;
  logic [31:0] quad_data = 32'h0;
  logic        quad_ready;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        pix_sof, pix_eol, pix_eof;

  logic        ready_level = 1'b1;
  logic        rand_en = 1'b0;
  logic        rnd = 1'b1;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [10:0] exp_q [$];
  logic        stalled = 1'b0;
  logic [10:0] held;

  assign pix_ready = rand_en ? rnd : ready_level;

  bayer_mosaic #(.WIDTH(4), .HEIGHT(2)) dut (
    .clk(clk), .rst(rst), .row_phase(row_phase), .col_phase(col_phase),
    .quad_valid(quad_valid), .quad_data(quad_data), .quad_ready(quad_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_pix(input logic [7:0] d, input logic sof, input logic eol, input logic eof);
    exp_q.push_back({sof, eol, eof, d});
  endtask

  // Eight pixels of a 4x2 frame, first pixel in bits [63:56].
  task automatic push_frame(input logic [63:0] px);
    for (int i = 0; i < 8; i++)
      push_pix(px[63-8*i -: 8], i == 0, (i == 3) || (i == 7), i == 7);
  endtask

  task automatic send_quad(input logic [31:0] q);
    int n;
    n = 0;
    quad_valid = 1'b1;
    quad_data  = q;
    @(negedge clk);
    while (!quad_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("quad_accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    quad_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      n++;
      @(posedge clk);
      #3;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    rnd = 1'($urandom_range(0, 1));
  end

  // Output monitor: scoreboard on handshakes, stability and quad_ready during stalls.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("stall_hold", {21'd0, pix_sof, pix_eol, pix_eof, pix_data}, {21'd0, held});
      stalled = 1'b0;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", {24'd0, pix_data}, 32'hFFFF_FFFF);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("pix_data", {24'd0, pix_data}, {24'd0, e[7:0]});
          check("pix_markers", {29'd0, pix_sof, pix_eol, pix_eof}, {29'd0, e[10:8]});
        end
      end else if (pix_valid && !pix_ready) begin
        check("quad_ready_in_stall", {31'd0, quad_ready}, 32'd0);
        held    = {pix_sof, pix_eol, pix_eof, pix_data};
        stalled = 1'b1;
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst_pix_data", {24'd0, pix_data}, 32'd0);
    check("rst_markers", {29'd0, pix_sof, pix_eol, pix_eof}, 32'd0);
    check("rst_quad_ready", {31'd0, quad_ready}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Phase 00
    push_frame(64'h11_22_55_66_33_44_77_88);
    send_quad(32'h11223344);
    send_quad(32'h55667788);
    drain();

    // Phase 11
    {row_phase, col_phase} = 2'b11;
    push_frame(64'h44_22_88_66_33_11_77_55);
    send_quad(32'h11223344);
    send_quad(32'h55667788);
    drain();

    // Phase 01, inputs changed to 10 mid-frame must be ignored
    {row_phase, col_phase} = 2'b01;
    push_frame(64'h22_11_66_55_44_33_88_77);
    send_quad(32'h11223344);
    {row_phase, col_phase} = 2'b10;
    send_quad(32'h55667788);
    drain();

    // Phase 10 sampled on this frame's first quad, then changed to 00
    push_frame(64'h22_44_66_88_11_33_55_77);
    send_quad(32'h11223344);
    {row_phase, col_phase} = 2'b00;
    send_quad(32'h55667788);
    drain();

    // Random backpressure over two frames
    rand_en = 1'b1;
    push_frame(64'hA1_B2_E5_F6_C3_D4_07_18);
    push_frame(64'h01_02_05_06_03_04_07_08);
    send_quad(32'hA1B2C3D4);
    send_quad(32'hE5F60718);
    send_quad(32'h01020304);
    send_quad(32'h05060708);
    drain();
    rand_en = 1'b0;

    // Quad gap: pix_valid must drop, then stream resumes in order
    push_frame(64'h01_02_05_06_03_04_07_08);
    send_quad(32'h01020304);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("gap_pix_valid_low", {31'd0, pix_valid}, 32'd0);
    @(posedge clk);
    #1;
    send_quad(32'h05060708);
    drain();

    // Reset while the bottom row is being emitted
    push_pix(8'h11, 1'b1, 1'b0, 1'b0);
    push_pix(8'h22, 1'b0, 1'b0, 1'b0);
    push_pix(8'h55, 1'b0, 1'b0, 1'b0);
    push_pix(8'h66, 1'b0, 1'b1, 1'b0);
    send_quad(32'h11223344);
    send_quad(32'h55667788);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    ready_level = 1'b0;
    check("bot_first_pixel", {24'd0, pix_data}, 32'h33);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("midrst_pix_data", {24'd0, pix_data}, 32'd0);
    check("midrst_markers", {29'd0, pix_sof, pix_eol, pix_eof}, 32'd0);
    check("midrst_quad_ready", {31'd0, quad_ready}, 32'd0);
    check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ready_level = 1'b1;
    push_frame(64'h11_22_55_66_33_44_77_88);
    send_quad(32'h11223344);
    send_quad(32'h55667788);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bayer_mosaic.md
# bayer_mosaic

Re-mosaicking serializer for the back end of the colour pipeline. Accepts one 32-bit {R,G1,G2,B} quad per 2x2 Bayer block in block-raster order and emits the original 8-bit Bayer pixel stream in pixel-raster order, restoring each sample to its sensor position for the frame's CFA phase. Bottom-row samples of each block row are held in an internal line buffer until the top pixel row has been sent. It sits between the per-quad processing stages and the pixel-serial output/DMA path.

## Interface
- WIDTH, 640, image width in pixels; even, >= 4
- HEIGHT, 480, image height in pixels; even, >= 2
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- row_phase  in  1  CFA row phase; sampled on first quad of each frame
- col_phase  in  1  CFA column phase; sampled with row_phase
- quad_valid  in  1  quad_data valid
- quad_data  in  32  {R[31:24], G1[23:16], G2[15:8], B[7:0]}
- quad_ready  out  1  quad accepted on an edge where quad_valid && quad_ready
- pix_valid  out  1  pix_data valid (registered)
- pix_data  out  8  Bayer sample (registered)
- pix_ready  in  1  downstream accepts pix_data on an edge where pix_valid && pix_ready
- pix_sof  out  1  qualifies first pixel of frame
- pix_eol  out  1  qualifies last pixel of each pixel row
- pix_eof  out  1  qualifies last pixel of frame

## Operation
- Position mapping (TL, TR, BL, BR) by phase {row,col}: 00 -> R,G1,G2,B; 01 -> G1,R,B,G2; 10 -> G1,B,R,G2; 11 -> B,G1,G2,R.
- Counters: blk (0..WIDTH/2-1), brow (0..HEIGHT/2-1), half (0/1). Line buffer: WIDTH/2 entries x 16 bits {BL,BR}, flop array, indexed by blk.
- "slot free" = !pix_valid || pix_ready.
- State TOP, half=0: quad_ready = slot free. On accept: pix_data<=TL, pix_valid<=1, TR held in register, {BL,BR} written to linebuf[blk], half<=1. If blk==0 && brow==0, phase inputs latched in the same edge and mapping for this quad uses the incoming phase values.
- TOP, half=1: quad_ready=0. When slot free: pix_data<=TR, half<=0; blk==WIDTH/2-1 -> blk<=0, state<=BOT; else blk++.
- BOT: quad_ready=0. When slot free: pix_data<=half ? linebuf[blk].BR : linebuf[blk].BL; half toggles; after BR of blk==WIDTH/2-1: blk<=0, state<=TOP, brow++ (wraps to 0 after HEIGHT/2-1, starting a new frame).
- When slot free and nothing new to load (TOP half=0 with no quad_valid): pix_valid<=0.
- pix_sof: TL of blk 0, brow 0. pix_eol: TR of last blk in TOP, BR of last blk in BOT. pix_eof: BR of last blk, last brow. Markers registered with pix_data and held while stalled.
- Reset (any time, incl. mid-frame): state TOP, blk/brow/half 0, phase 00, pix_valid 0, pix_data 0x00, all markers 0, quad_ready 0 while rst high; partial frame discarded, line buffer contents don't-care.

## Timing
- Latency: quad accepted at edge k -> TL on pix_data after edge k, TR after next slot-free edge.
- Peak throughput 1 pixel/cycle with pix_ready held high; quad acceptance at most every 2nd cycle in TOP, none in BOT.
- pix_data/pix_valid/markers stable while pix_valid && !pix_ready.
- quad_ready is combinational from state, half, pix_valid, pix_ready; never depends on quad_valid.
- Phase inputs ignored except on first quad of a frame.

## Test plan
- WIDTH=4, HEIGHT=2, phase 00, pix_ready=1, quads 0x11223344, 0x55667788 -> pixels 11,22,55,66,33,44,77,88; sof on first, eol on 4th and 8th, eof on 8th.
- Same quads, phase 11 -> pixels 44,22,88,66,33,11,77,55.
- Phase 01 then 10 on successive frames with phase inputs changed mid-frame -> mapping follows value sampled at first quad only; 10 on 0x11223344 gives TL,TR,BL,BR = 22,44,11,33.
- pix_ready toggled 1-0-1 randomly -> no pixel lost or duplicated, pix_data stable while stalled, quad_ready 0 during stall.
- Quad gaps (quad_valid low 3 cycles) -> pix_valid drops to 0, stream resumes in order.
- Assert rst mid-BOT row -> all outputs 0 same cycle, next quad treated as blk 0 brow 0 with sof.
